// File: rtl/seg_msg_scroller.sv
// Message sequencer for a bank of seven_seg displays: shows a short buffer of
// display codes statically or scrolls it right-to-left, with optional blinking.
module seg_msg_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int TICK_DIV   = 25000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]    wr_addr,
  input  logic [4:0]                    wr_data,
  input  logic [$clog2(MSG_LEN):0]      msg_len,
  input  logic                          repeat_en,
  input  logic                          blink_en,
  input  logic                          start,
  input  logic                          stop,
  output logic                          busy,
  output logic                          done,
  output logic [5*NUM_DIGITS-1:0]       digit_value,
  output logic [NUM_DIGITS-1:0]         digit_en
);

  localparam int AW  = $clog2(MSG_LEN);
  localparam int PW  = AW + 1;
  localparam int IW  = $clog2(MSG_LEN + NUM_DIGITS) + 1;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [4:0]    BCD_BLANK  = 5'h1F;
  localparam logic [PW-1:0] LEN_MAX    = PW'(MSG_LEN);
  localparam logic [PW-1:0] LEN_STATIC = PW'(NUM_DIGITS);
  localparam logic [PW-1:0] LEN_ONE    = PW'(1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, STATIC, SCROLL} state_t;

  state_t                    state_q, state_d;
  logic [4:0]                buf_q [MSG_LEN];
  logic [4:0]                buf_d [MSG_LEN];
  logic [PW-1:0]             pos_q, pos_d;
  logic [PW-1:0]             len_q, len_d;
  logic                      rep_q, rep_d;
  logic [TW-1:0]             presc_q, presc_d;
  logic [BW-1:0]             bcnt_q, bcnt_d;
  logic                      phase_q, phase_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [5*NUM_DIGITS-1:0]   dv_q, dv_d;
  logic [NUM_DIGITS-1:0]     den_q, den_d;
  logic [IW-1:0]             idx;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    len_d   = len_q;
    rep_d   = rep_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    dv_d    = dv_q;
    den_d   = '0;
    idx     = '0;

    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          if (msg_len == '0)          len_d = LEN_ONE;
          else if (msg_len > LEN_MAX) len_d = LEN_MAX;
          else                        len_d = msg_len;
          rep_d   = repeat_en;
          pos_d   = '0;
          presc_d = '0;
          bcnt_d  = '0;
          phase_d = 1'b1;
          state_d = (len_d <= LEN_STATIC) ? STATIC : SCROLL;
        end else if (wr_en) begin
          buf_d[wr_addr] = wr_data;
        end
      end
      STATIC: begin
        if (stop) state_d = IDLE;
      end
      SCROLL: begin
        if (stop) begin
          state_d = IDLE;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (pos_q != len_q) begin
            pos_d = pos_q + LEN_ONE;
          end else if (rep_q) begin
            pos_d = '0;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Blink phase free-runs for as long as the controller stays busy.
    if (state_q != IDLE && state_d != IDLE) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end

    busy_d = (state_d != IDLE);

    // Window is built from next-cycle pos/len so it lands with the state change.
    if (busy_d) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        idx = IW'(pos_d) + IW'(NUM_DIGITS - 1 - j);
        if (idx < IW'(len_d)) dv_d[5*j +: 5] = buf_q[idx[AW-1:0]];
        else                  dv_d[5*j +: 5] = BCD_BLANK;
      end
      den_d = blink_en ? {NUM_DIGITS{phase_d}} : {NUM_DIGITS{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= BCD_BLANK;
      pos_q   <= '0;
      len_q   <= LEN_ONE;
      rep_q   <= 1'b0;
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dv_q    <= {NUM_DIGITS{BCD_BLANK}};
      den_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
      den_q   <= den_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign digit_value = dv_q;
  assign digit_en    = den_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Directed bench for seg_msg_scroller: vector table plus hand-written
// scroll, repeat, clamp, blink and reset sequences.
module tb_seg_msg_scroller;

  localparam logic [4:0] B = 5'h1F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [3:0]  msg_len;
  logic        repeat_en, blink_en, start, stop;
  logic        busy, done;
  logic [19:0] digit_value;
  logic [3:0]  digit_en;

  int checks = 0;
  int errors = 0;

  seg_msg_scroller #(.NUM_DIGITS(4), .MSG_LEN(8), .TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .repeat_en(repeat_en), .blink_en(blink_en), .start(start),
    .stop(stop), .busy(busy), .done(done), .digit_value(digit_value), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [4:0]  wr_data;
    logic [3:0]  msg_len;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [19:0] val;
    logic [3:0]  en;
  } vec_t;

  vec_t tbl [11];

  // Buffer contents after the scroll test writes codes 0..5 (6,7 left blank).
  logic [4:0] msg_m [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] len, input logic rep);
    msg_len = len; repeat_en = rep; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  function automatic logic [19:0] win(input int p, input int len);
    logic [19:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int k;
      k = p + 3 - j;
      r[5*j +: 5] = (k < len && k < 8) ? msg_m[k] : B;
    end
    return r;
  endfunction

  initial begin
    int dcnt;
    msg_m = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, B, B};
    //            wr  addr dat len st sp busy done value                     en
    tbl[0]  = '{1'b1, 3'd0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, {B, B, B, B},          4'h0};
    tbl[1]  = '{1'b1, 3'd1, 5'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, {B, B, B, B},          4'h0};
    tbl[2]  = '{1'b0, 3'd0, 5'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, {5'd1, 5'd2, B, B},    4'hF};
    tbl[3]  = '{1'b0, 3'd0, 5'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, {5'd1, 5'd2, B, B},    4'hF};
    tbl[4]  = '{1'b1, 3'd0, 5'd7, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, {5'd1, 5'd2, B, B},    4'hF};
    tbl[5]  = '{1'b0, 3'd0, 5'd0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, {5'd1, 5'd2, B, B},    4'hF};
    tbl[6]  = '{1'b0, 3'd0, 5'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, {5'd1, 5'd2, B, B},    4'h0};
    tbl[7]  = '{1'b0, 3'd0, 5'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, {5'd1, 5'd2, B, B},    4'h0};
    tbl[8]  = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, {5'd1, B, B, B},       4'hF};
    tbl[9]  = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, {5'd1, B, B, B},       4'hF};
    tbl[10] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, {5'd1, B, B, B},       4'h0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    repeat_en = 1'b0; blink_en = 1'b0; start = 1'b0; stop = 1'b0;
    step(); step();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_value", digit_value, {B, B, B, B});
    chk("reset_en", digit_en, 4'h0);
    rst_n = 1'b1;
    step();

    // Static display, ignored write/start while busy, stop, start+stop, len 0.
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      msg_len = tbl[i].msg_len; start = tbl[i].start; stop = tbl[i].stop;
      step();
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_value", i), digit_value, tbl[i].val);
      chk($sformatf("vec%0d_en", i), digit_en, tbl[i].en);
      if (i == 3) begin
        dcnt = 0;
        for (int k = 0; k < 50; k++) begin
          step();
          if (done) dcnt++;
        end
        chk("static_hold_done", dcnt, 0);
        chk("static_hold_busy", busy, 1'b1);
      end
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;

    // One-shot scroll of codes 0..5.
    for (int a = 0; a < 6; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 5'(a);
      step();
    end
    wr_en = 1'b0;
    pulse_start(4'd6, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      if (k < 28) begin
        chk($sformatf("scroll_k%0d_busy", k), busy, 1'b1);
        chk($sformatf("scroll_k%0d_done", k), done, 1'b0);
        chk($sformatf("scroll_k%0d_value", k), digit_value, win(k / 4, 6));
        chk($sformatf("scroll_k%0d_en", k), digit_en, 4'hF);
      end else if (k == 28) begin
        chk("scroll_end_done", done, 1'b1);
        chk("scroll_end_busy", busy, 1'b0);
        chk("scroll_end_value", digit_value, {B, B, B, B});
        chk("scroll_end_en", digit_en, 4'h0);
      end else begin
        chk($sformatf("scroll_k%0d_done", k), done, 1'b0);
        chk($sformatf("scroll_k%0d_busy", k), busy, 1'b0);
      end
      step();
    end
    chk("scroll_first_window", win(0, 6), {5'd0, 5'd1, 5'd2, 5'd3});

    // Repeating scroll wraps back to the start and never signals done.
    pulse_start(4'd6, 1'b1);
    dcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) dcnt++;
      if (k == 24) chk("repeat_blank", digit_value, {B, B, B, B});
      if (k == 28) chk("repeat_wrap", digit_value, {5'd0, 5'd1, 5'd2, 5'd3});
      if (k == 99) chk("repeat_busy", busy, 1'b1);
      step();
    end
    chk("repeat_no_done", dcnt, 0);
    pulse_stop();
    chk("repeat_stop_busy", busy, 1'b0);
    chk("repeat_stop_en", digit_en, 4'h0);

    // msg_len 12 clamps to 8: nine ticks until done.
    pulse_start(4'd12, 1'b0);
    for (int k = 0; k <= 37; k++) begin
      if (k == 0)  chk("clamp_k0", digit_value, {5'd0, 5'd1, 5'd2, 5'd3});
      if (k == 4)  chk("clamp_k4", digit_value, {5'd1, 5'd2, 5'd3, 5'd4});
      if (k == 20) chk("clamp_k20", digit_value, {5'd5, B, B, B});
      if (k == 35) chk("clamp_k35_busy", busy, 1'b1);
      if (k == 35) chk("clamp_k35_done", done, 1'b0);
      if (k == 36) chk("clamp_k36_done", done, 1'b1);
      if (k == 37) chk("clamp_k37_busy", busy, 1'b0);
      step();
    end

    // Blink in STATIC: 3 cycles on, 3 off, then drop blink_en while off.
    blink_en = 1'b1;
    pulse_start(4'd2, 1'b0);
    chk("blink_value", digit_value, {5'd0, 5'd1, B, B});
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("blink_k%0d_en", k), digit_en, ((k / 3) % 2 == 0) ? 4'hF : 4'h0);
      if (k < 10) step();
    end
    blink_en = 1'b0;
    step();
    chk("blink_drop_en", digit_en, 4'hF);
    pulse_stop();

    // Asynchronous reset in the middle of a scroll clears everything.
    pulse_start(4'd6, 1'b1);
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_value", digit_value, {B, B, B, B});
    chk("async_rst_en", digit_en, 4'h0);
    step();
    rst_n = 1'b1;
    step();
    pulse_start(4'd4, 1'b0);
    chk("post_rst_busy", busy, 1'b1);
    chk("post_rst_buffer", digit_value, {B, B, B, B});
    chk("post_rst_en", digit_en, 4'hF);
    pulse_stop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_msg_scroller.md
Name: seg_msg_scroller

Overview:
Sequencing controller for the bank of seven_seg display instances. It holds a short message of 5-bit display codes from constants.h (digits, letters, BCD_NEG, BCD_BLANK). It drives each display's value and en inputs to show the message statically, or to scroll it right-to-left at a programmable rate, with optional blinking. It sits between the project's top-level control FSM and the seven_seg instances.

Parameters:
NUM_DIGITS, 4, number of seven_seg instances driven (>=2)
MSG_LEN, 16, message buffer depth in codes (power of 2, >NUM_DIGITS)
TICK_DIV, 25000000, clk cycles per scroll step
BLINK_DIV, 12500000, clk cycles per blink half-period

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write message buffer (honoured only in IDLE)
wr_addr  in  log2(MSG_LEN)  buffer index
wr_data  in  5  display code
msg_len  in  log2(MSG_LEN)+1  message length, sampled on start
repeat_en  in  1  loop scroll, sampled on start
blink_en  in  1  live blink enable
start  in  1  single-cycle start request
stop  in  1  single-cycle abort
busy  out  1  high in STATIC or SCROLL
done  out  1  one-cycle pulse at scroll completion
digit_value  out  5*NUM_DIGITS  code for display j at [5j+4:5j]; j=0 is rightmost (HEX0)
digit_en  out  NUM_DIGITS  en for display j

Behaviour:
- Reset (async, rst_n low): state IDLE; all buffer entries, and all digit_value fields, set to `BCD_BLANK. pos=0, prescaler=0, blink phase=1. digit_en=0, busy=0, done=0. Release needs no start-up sequence.
- All outputs are registered. Effects of inputs appear on the next rising edge.
- States: IDLE, STATIC, SCROLL.
- IDLE: wr_en writes wr_data to buffer[wr_addr]. digit_en=0.
  - start: latch len = msg_len, clamped to 1..MSG_LEN (0 becomes 1, >MSG_LEN becomes MSG_LEN), and latch repeat_en.
  - Clear pos, prescaler and blink counter; set blink phase=1.
  - Go to STATIC if len<=NUM_DIGITS, else SCROLL.
  - busy=1 and the first window appear on the edge after start.
- Stream definition: stream[k] = buffer[k] for k<len, else `BCD_BLANK. Display j shows stream[pos + NUM_DIGITS-1-j], so the leftmost display shows stream[pos].
- STATIC: pos held at 0; message left-justified, unused displays BLANK. No done pulse. Remains until stop.
- SCROLL:
  - The prescaler counts 0..TICK_DIV-1; a tick occurs when prescaler == TICK_DIV-1.
  - On a tick with pos<len: pos increments and the window shifts left one position on the same edge.
  - On a tick with pos==len (window all BLANK):
    - repeat=1: pos returns to 0.
    - repeat=0: done pulses for 1 cycle, state goes to IDLE, busy=0 on that edge.
  - The pos arithmetic width is log2(MSG_LEN)+1, and the index is never out of range.
- digit_en, in STATIC/SCROLL: all ones when blink_en=0; when blink_en=1, all bits = blink phase.
  - Blink phase toggles every BLINK_DIV cycles and is free-running while busy.
  - Deasserting blink_en gives all ones on the next edge.
- stop: from any state go to IDLE next edge, busy=0, digit_en=0, no done. stop and start in the same cycle: stop wins (stays or returns to IDLE).
- start while busy: ignored. wr_en while busy: ignored, buffer unchanged.
- On return to IDLE, digit_value holds its last window; only digit_en blanks the displays.
- Mid-operation async reset: immediate return to the reset values above, buffer cleared.

Test Plan:
(All with NUM_DIGITS=4, MSG_LEN=8, TICK_DIV=4, BLINK_DIV=3.)
1. Reset pulse mid-run → digit_en=0000, busy=0, done=0, every digit_value field=BLANK, immediately and asynchronously.
2. Static case: write BCD_1, BCD_2 at addr 0,1; msg_len=2; start → next edge busy=1, HEX3=1, HEX2=2, HEX1/HEX0=BLANK, digit_en=1111. Hold 50 cycles with no done, then stop → busy=0 and digit_en=0000 next edge.
3. Scroll case: write codes 0..5, msg_len=6, repeat_en=0, start → window 0,1,2,3. After 4 cycles 1,2,3,4, then 2,3,4,5, ... then all BLANK at pos=6. done pulses exactly 28 cycles after start (7th tick), then busy=0.
4. repeat_en=1, same message → after the all-BLANK window the next tick shows 0,1,2,3 again, done never asserts over 100 cycles.
5. Boundary case: msg_len=0 → STATIC showing buffer[0] only. msg_len=12 → clamped to 8, enters SCROLL. wr_en while busy → buffer unchanged, verified after stop plus restart. start+stop in the same cycle → stays IDLE.
6. Blink case: blink_en=1 in STATIC → digit_en toggles 1111/0000 every 3 cycles. blink_en dropped → 1111 next edge.
